esm_fetch_queue: RTL and testbench
==================================

// Module: esm_fetch_queue
// PURPOSE
//  Upstream instruction-supply stage for the ESM block: fetches instruction words from instruction memory
//  and drives them on the ESM Instr_in port, one per clk, through a DEPTH-entry prefetch FIFO.
//  Inserts a NOP while the FIFO is empty, and drives all-zero after the program-end marker.
//  The all-zero word is the encoding ESM treats as "stream complete, drain buffer".
// PARAMETERS
//  Instruction_word_size  32            instruction width
//  ADDR_W                 32            byte address width
//  DEPTH                  4             FIFO entries (power of 2, >=2); also max outstanding requests
//  NOP                    32'h00000013  bubble word (addi x0,x0,0)
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  start       in   1       1-cycle pulse: begin fetching at start_addr (ignored unless IDLE or DONE)
//  start_addr  in   ADDR_W  first fetch address, word aligned
//  stall       in   1       hold Instr_out, no FIFO pop
//  imem_req    out  1       read request, one word
//  imem_addr   out  ADDR_W  request address
//  imem_rdata  in   Instruction_word_size  returned word
//  imem_rvalid in   1       rdata valid; in-order, >=1 cycle after req, no backpressure
//  Instr_out   out  Instruction_word_size  to ESM Instr_in
//  instr_valid out  1       Instr_out carries a real fetched instruction (not NOP/zero)
//  pc_out      out  ADDR_W  address of the word on Instr_out when instr_valid
//  busy        out  1       state is FETCH or DRAIN
//  done        out  1       state is DONE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; FIFO empty; outstanding=0; imem_req=0; imem_addr=0.
//   Instr_out=0; instr_valid=0; pc_out=0; busy=0; done=0.
//  FSM:
//   IDLE->FETCH on start: fetch_pc<=start_addr.
//   FETCH->DRAIN when a returned word ==0 (end marker). The marker is not enqueued, and no further reqs are issued.
//   DRAIN->DONE when the FIFO is empty and outstanding==0. Words returning after the marker are discarded.
//   DONE->FETCH on start (restart). start while in FETCH or DRAIN is ignored.
//  Request rule: imem_req=1 in FETCH when count+outstanding < DEPTH. Also requires that no marker is seen this cycle.
//   On each req: imem_addr=fetch_pc, fetch_pc+=4, outstanding+=1. rvalid: outstanding-=1.
//   Same-cycle req+rvalid leaves outstanding unchanged.
//  FIFO: push on rvalid with nonzero rdata in FETCH; {rdata, addr} is stored.
//   Overflow is impossible by the credit rule; assert count<=DEPTH. Push and pop in the same cycle are both allowed.
//   When full, pop-then-push frees the slot. A pop from empty never occurs.
//   Rd/wr pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//  Output register (1-cycle latency, pop -> Instr_out next edge), when stall=0:
//   FIFO non-empty: pop; Instr_out<=word, pc_out<=addr, instr_valid<=1.
//   FIFO empty in IDLE, FETCH or DRAIN: Instr_out<=NOP, instr_valid<=0.
//   DONE, or DRAIN->DONE edge: Instr_out<=0, instr_valid<=0.
//  stall=1: Instr_out, pc_out and instr_valid hold; no pop. Requests continue under the credit rule.
//  Min fetch-to-output latency: req at t, rvalid at t+1, push at edge t+1, pop at t+2, Instr_out valid after edge t+2.
//  Reset mid-operation: all state is cleared immediately. A late rvalid after reset is ignored, since outstanding=0.
//  Address wraps modulo 2^ADDR_W.
// TESTING
//  1. Reset, start_addr=0x100, mem 0x100..0x10C = A,B,C,D, 0x110=0; memory latency 1.
//     Expect Instr_out A,B,C,D on consecutive cycles with pc 0x100..0x10C.
//     Then Instr_out=0, done=1, and exactly 5 reqs issued in total.
//  2. Same program, memory latency 3. Expect NOP bubbles with instr_valid=0 between words.
//     Word order is unchanged, and outstanding never exceeds DEPTH=4.
//  3. stall=1 for 6 cycles mid-stream. Expect Instr_out frozen on the current word.
//     imem_req drops once count+outstanding==4, and the output resumes in order with no word lost or duplicated.
//  4. Marker at 0x104 while reqs for 0x108 and 0x10C are outstanding. Returned words are discarded.
//     The DONE transition waits for outstanding==0.
//  5. rst_n low for 1 cycle at an arbitrary point mid-FETCH, with a non-clock-aligned edge.
//     All outputs go to reset values asynchronously; a new start refetches correctly.
//  6. start_addr=0xFFFF_FFF8 with ADDR_W=32. Expect fetch addresses to wrap to 0x0, and pc_out to follow.

Source files
------------

// File: rtl/esm_fetch_queue_if.sv
// Instruction-memory read bus between the fetch queue (master) and the
// instruction memory (slave). One-word requests, in-order responses, no
// backpressure on the response side.
interface esm_fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_rvalid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_rvalid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_rvalid
    );
endinterface

// File: rtl/esm_fetch_queue.sv
// Instruction-supply stage for ESM: fetches words from instruction memory
// through a DEPTH-entry prefetch FIFO and presents one word per clock on
// Instr_out. Emits NOP while starved and all-zero once the program-end
// marker (a zero word) has been seen and everything in flight has drained.
module esm_fetch_queue #(
    parameter int                               Instruction_word_size = 32,
    parameter int                               ADDR_W                = 32,
    parameter int                               DEPTH                 = 4,
    parameter logic [Instruction_word_size-1:0] NOP                   = 32'h00000013
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_W-1:0]                start_addr,
    input  logic                             stall,
    esm_fetch_queue_if.master                imem,
    output logic [Instruction_word_size-1:0] Instr_out,
    output logic                             instr_valid,
    output logic [ADDR_W-1:0]                pc_out,
    output logic                             busy,
    output logic                             done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] LIMIT = (CNT_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                           r_state;
    state_t                           w_next;
    logic [ADDR_W-1:0]                r_fetch_pc;
    logic [ADDR_W-1:0]                r_ret_pc;
    logic [CNT_W-1:0]                 r_outst;
    logic [CNT_W-1:0]                 r_cnt;
    logic [PTR_W-1:0]                 r_rd_ptr;
    logic [PTR_W-1:0]                 r_wr_ptr;
    logic [Instruction_word_size-1:0] r_fifo_word [DEPTH];
    logic [ADDR_W-1:0]                r_fifo_addr [DEPTH];
    logic [Instruction_word_size-1:0] r_instr;
    logic [ADDR_W-1:0]                r_pc;
    logic                             r_valid;

    logic                             w_rv;
    logic                             w_marker;
    logic                             w_push;
    logic                             w_pop;
    logic                             w_req;
    logic                             w_start_ok;
    logic [CNT_W:0]                   w_credit;

    // A response only counts while something is outstanding, so stale
    // responses arriving after a reset are dropped.
    assign w_rv       = imem.imem_rvalid && (r_outst != '0);
    assign w_marker   = (r_state == S_FETCH) && w_rv && (imem.imem_rdata == '0);
    assign w_push     = (r_state == S_FETCH) && w_rv && (imem.imem_rdata != '0);
    assign w_pop      = !stall && (r_cnt != '0);
    assign w_credit   = {1'b0, r_cnt} + {1'b0, r_outst};
    assign w_req      = (r_state == S_FETCH) && !w_marker && (w_credit < LIMIT);
    assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_fetch_pc;
    assign Instr_out      = r_instr;
    assign instr_valid    = r_valid;
    assign pc_out         = r_pc;
    assign busy           = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: DRAIN waits for both the FIFO and the memory pipe to empty.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)    w_next = S_FETCH;
            S_FETCH: if (w_marker) w_next = S_DRAIN;
            S_DRAIN: if ((r_cnt == '0) && (r_outst == '0)) w_next = S_DONE;
            S_DONE:  if (start)    w_next = S_FETCH;
            default: w_next = S_IDLE;
        endcase
    end

    // Request address and the address of the next word due back (responses are in order).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= '0;
            r_ret_pc   <= '0;
        end else if (w_start_ok) begin
            r_fetch_pc <= start_addr;
            r_ret_pc   <= start_addr;
        end else begin
            if (w_req) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            if (w_rv)  r_ret_pc   <= r_ret_pc + ADDR_W'(4);
        end
    end

    // Outstanding-request counter; simultaneous req and response cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_outst <= '0;
        else if (w_req && !w_rv) r_outst <= r_outst + CNT_W'(1);
        else if (!w_req && w_rv) r_outst <= r_outst - CNT_W'(1);
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_push && w_pop) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // FIFO storage: word plus the address it was fetched from.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_word[r_wr_ptr] <= imem.imem_rdata;
            r_fifo_addr[r_wr_ptr] <= r_ret_pc;
        end
    end

    // Output register: real word when available, else NOP, or zero once finished.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            if (w_pop) begin
                r_instr <= r_fifo_word[r_rd_ptr];
                r_pc    <= r_fifo_addr[r_rd_ptr];
                r_valid <= 1'b1;
            end else if ((r_state == S_DONE) || (w_next == S_DONE)) begin
                r_instr <= '0;
                r_valid <= 1'b0;
            end else begin
                r_instr <= NOP;
                r_valid <= 1'b0;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) r_cnt <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_esm_fetch_queue.sv
// Directed testbench for esm_fetch_queue with a variable-latency memory model.
module tb_esm_fetch_queue;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, mem_flush;
    logic [31:0] start_addr;
    logic [31:0] Instr_out, pc_out;
    logic        instr_valid, busy, done;

    always #5 clk = ~clk;

    esm_fetch_queue_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    esm_fetch_queue #(
        .Instruction_word_size(32), .ADDR_W(32), .DEPTH(4), .NOP(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .stall(stall), .imem(bus), .Instr_out(Instr_out),
        .instr_valid(instr_valid), .pc_out(pc_out), .busy(busy), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- memory model ----------------
    logic [31:0] prog [16];
    logic [31:0] prog_base;
    int          mem_lat = 1;
    logic        pv [8];
    logic [31:0] pa [8];

    function automatic logic [31:0] word_of(input int i);
        return 32'hA5000000 + 32'(i * 17 + 1);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - prog_base;
        if (off[1:0] == 2'b00 && off < 32'd64) return prog[off[5:2]];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (mem_flush) begin
            for (int i = 0; i < 8; i++) begin pv[i] <= 1'b0; pa[i] <= 32'h0; end
        end else begin
            for (int i = 7; i > 0; i--) begin pv[i] <= pv[i-1]; pa[i] <= pa[i-1]; end
            pv[0] <= bus.imem_req;
            pa[0] <= bus.imem_addr;
        end
    end

    assign bus.imem_rvalid = pv[mem_lat-1];
    assign bus.imem_rdata  = pv[mem_lat-1] ? mem_word(pa[mem_lat-1]) : 32'h0;

    // ---------------- monitor ----------------
    logic [31:0] log_w  [64];
    logic [31:0] log_pc [64];
    int log_n, n_req, outst_m, max_outst, nop_bubbles, done_early;

    always @(posedge clk) begin
        logic st;
        logic pend;
        st   = stall;
        pend = 1'b0;
        for (int i = 0; i < mem_lat; i++) pend = pend | pv[i];
        if (rst_n) begin
            if (bus.imem_req) n_req++;
            if (bus.imem_req) outst_m++;
            if (bus.imem_rvalid && outst_m > 0) outst_m--;
            if (outst_m > max_outst) max_outst = outst_m;
            if (done && pend) done_early++;
        end
        #1;
        if (rst_n && !st) begin
            if (instr_valid) begin
                if (log_n < 64) begin log_w[log_n] = Instr_out; log_pc[log_n] = pc_out; end
                log_n++;
            end else if (Instr_out == NOP && log_n > 0) begin
                nop_bubbles++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_prog(input logic [31:0] base, input int n);
        prog_base = base;
        for (int i = 0; i < 16; i++) prog[i] = (i < n) ? word_of(i) : 32'h0;
    endtask

    task automatic pulse_start(input logic [31:0] addr);
        @(negedge clk);
        log_n = 0; n_req = 0; outst_m = 0; max_outst = 0; nop_bubbles = 0; done_early = 0;
        start_addr = addr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; return; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0; stall = 1'b0; mem_flush = 1'b1; start_addr = 32'h0;
        #3 rst_n = 1'b0;
        #1;
        n_tests++; if (Instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", Instr_out); end
        n_tests++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc_out); end
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b want 00", {busy, done}); end
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
        n_tests++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mem_flush = 1'b0;
        n_tests++; if (Instr_out !== NOP) begin n_fail++; $display("FAIL idle_nop: got %h want %h", Instr_out, NOP); end
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL idle_state: got %b want 00", {busy, done}); end
    endtask

    task automatic test_basic();
        mem_lat = 1;
        set_prog(32'h100, 4);
        pulse_start(32'h100);
        for (int i = 0; i < 20 && !instr_valid; i++) @(negedge clk);
        n_tests++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first_valid: got %b want 1", instr_valid); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (Instr_out !== word_of(k) || pc_out !== 32'h100 + 32'(4 * k) || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h@%h v%b want %h@%h v1", k, Instr_out, pc_out, instr_valid, word_of(k), 32'h100 + 32'(4 * k));
            end
            @(negedge clk);
        end
        n_tests++; if (Instr_out !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_zero: got %h v%b want 0 v0", Instr_out, instr_valid); end
        n_tests++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done%b busy%b want done1 busy0", done, busy); end
        n_tests++; if (n_req !== 5) begin n_fail++; $display("FAIL basic_reqs: got %0d want 5", n_req); end
    endtask

    task automatic test_latency();
        bit ok;
        mem_lat = 3;
        set_prog(32'h100, 4);
        pulse_start(32'h100);
        repeat (3) @(negedge clk);
        start_addr = 32'h200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL lat_done: got timeout want done"); end
        n_tests++; if (log_n !== 4) begin n_fail++; $display("FAIL lat_count: got %0d want 4", log_n); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (log_w[k] !== word_of(k) || log_pc[k] !== 32'h100 + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL lat_word%0d: got %h@%h want %h@%h", k, log_w[k], log_pc[k], word_of(k), 32'h100 + 32'(4 * k));
            end
        end
        n_tests++; if (nop_bubbles < 1) begin n_fail++; $display("FAIL lat_bubbles: got %0d want >=1", nop_bubbles); end
        n_tests++; if (max_outst > 4) begin n_fail++; $display("FAIL lat_outstanding: got %0d want <=4", max_outst); end
        n_tests++; if (Instr_out !== 32'h0) begin n_fail++; $display("FAIL lat_zero: got %h want 0", Instr_out); end
    endtask

    task automatic test_stall();
        bit ok;
        logic [31:0] held_w, held_pc;
        mem_lat = 1;
        set_prog(32'h100, 8);
        pulse_start(32'h100);
        for (int i = 0; i < 20 && log_n < 2; i++) @(negedge clk);
        stall = 1'b1;
        @(negedge clk);
        held_w = Instr_out; held_pc = pc_out;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (Instr_out !== held_w || pc_out !== held_pc || instr_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got %h@%h v%b want %h@%h v1", k, Instr_out, pc_out, instr_valid, held_w, held_pc);
            end
        end
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_drop: got %b want 0", bus.imem_req); end
        stall = 1'b0;
        wait_done(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stall_done: got timeout want done"); end
        n_tests++; if (log_n !== 8) begin n_fail++; $display("FAIL stall_count: got %0d want 8", log_n); end
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (log_w[k] !== word_of(k) || log_pc[k] !== 32'h100 + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stall_word%0d: got %h@%h want %h@%h", k, log_w[k], log_pc[k], word_of(k), 32'h100 + 32'(4 * k));
            end
        end
        n_tests++; if (max_outst > 4) begin n_fail++; $display("FAIL stall_outstanding: got %0d want <=4", max_outst); end
    endtask

    task automatic test_marker();
        bit ok;
        mem_lat = 3;
        set_prog(32'h100, 1);
        prog[2] = 32'hBEEF0002;
        prog[3] = 32'hBEEF0003;
        pulse_start(32'h100);
        wait_done(100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL marker_done: got timeout want done"); end
        n_tests++; if (log_n !== 1 || log_w[0] !== word_of(0)) begin n_fail++; $display("FAIL marker_words: got n=%0d w0=%h want n=1 w0=%h", log_n, log_w[0], word_of(0)); end
        n_tests++; if (n_req !== 4) begin n_fail++; $display("FAIL marker_reqs: got %0d want 4", n_req); end
        n_tests++; if (done_early !== 0) begin n_fail++; $display("FAIL marker_done_early: got %0d want 0", done_early); end
        n_tests++; if (Instr_out !== 32'h0) begin n_fail++; $display("FAIL marker_zero: got %h want 0", Instr_out); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        mem_lat = 3;
        set_prog(32'h100, 4);
        pulse_start(32'h100);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_tests++; if (Instr_out !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_instr: got %h v%b want 0 v0", Instr_out, instr_valid); end
        n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rmid_pc: got %h want 0", pc_out); end
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL rmid_state: got %b want 00", {busy, done}); end
        n_tests++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_bus: got req%b addr %h want req0 addr 0", bus.imem_req, bus.imem_addr); end
        #8 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++; if ({busy, done} !== 2'b00 || Instr_out !== NOP) begin n_fail++; $display("FAIL rmid_idle: got %b %h want 00 %h", {busy, done}, Instr_out, NOP); end
        pulse_start(32'h100);
        wait_done(100, ok);
        n_tests++; if (!ok || log_n !== 4) begin n_fail++; $display("FAIL rmid_refetch: got ok%b n=%0d want ok1 n=4", ok, log_n); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (log_w[k] !== word_of(k) || log_pc[k] !== 32'h100 + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL rmid_word%0d: got %h@%h want %h@%h", k, log_w[k], log_pc[k], word_of(k), 32'h100 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000; exp_pc[3] = 32'h0000_0004;
        mem_lat = 1;
        set_prog(32'hFFFF_FFF8, 4);
        pulse_start(32'hFFFF_FFF8);
        wait_done(100, ok);
        n_tests++; if (!ok || log_n !== 4) begin n_fail++; $display("FAIL wrap_done: got ok%b n=%0d want ok1 n=4", ok, log_n); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (log_w[k] !== word_of(k) || log_pc[k] !== exp_pc[k]) begin
                n_fail++;
                $display("FAIL wrap_word%0d: got %h@%h want %h@%h", k, log_w[k], log_pc[k], word_of(k), exp_pc[k]);
            end
        end
        n_tests++; if (n_req !== 5) begin n_fail++; $display("FAIL wrap_reqs: got %0d want 5", n_req); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_stall();
        test_marker();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
